// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - interrupt controller: synchronised edge-detected requests, mask, single INT line
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst         asynchronous active-low reset
//   irq         asynchronous level request lines from peripherals
//   trap_taken  1-cycle pulse, CPU entered the trap handler for INT
//   mret        1-cycle pulse, CPU executed mret
//   sel/we      MMIO select and write enable
//   addr        word offset: 0 PENDING (W1C), 1 MASK, 2 CAUSE (RO), 3 reserved
//   wdata       MMIO write data
//   rdata       MMIO read data, combinational from addr, 0 when sel=0
//   INT         registered interrupt request to the CPU
//   in_service  registered, high while a handler is running
module int_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               trap_taken,
    input  logic               mret,
    input  logic               sel,
    input  logic               we,
    input  logic [1:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               INT,
    output logic               in_service
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] s1_q, s2_q, s3_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               cause_v_q, cause_v_d;
    logic [3:0]         cause_id_q, cause_id_d;
    logic               int_q, int_d;
    logic               insv_q, insv_d;

    logic [NUM_IRQ-1:0] edge_v;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] win_oh;
    logic [3:0]         win_id;
    logic               wr_pend, wr_mask;

    // Only the low NUM_IRQ bits of wdata carry register content.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:NUM_IRQ];

    assign edge_v  = s2_q & ~s3_q;
    assign active  = pend_q & mask_q;
    // Isolate the lowest set bit: bit 0 has the highest priority.
    assign win_oh  = active & (~active + NUM_IRQ'(1));
    assign wr_pend = sel && we && (addr == 2'd0);
    assign wr_mask = sel && we && (addr == 2'd1);

    always_comb begin
        win_id = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_id = 4'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cause_v_d  = cause_v_q;
        cause_id_d = cause_id_q;
        mask_d     = wr_mask ? wdata[NUM_IRQ-1:0] : mask_q;
        pend_d     = wr_pend ? (pend_q & ~wdata[NUM_IRQ-1:0]) : pend_q;

        case (state_q)
            ST_IDLE: begin
                if (active != '0) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (trap_taken && (active != '0)) begin
                    state_d    = ST_SERVICE;
                    pend_d     = pend_d & ~win_oh;
                    cause_v_d  = 1'b1;
                    cause_id_d = win_id;
                end else if (active == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (mret) begin
                    state_d   = ST_IDLE;
                    cause_v_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Fresh edges are applied last so they win over W1C and claim clears.
        pend_d = pend_d | edge_v;
        int_d  = (state_d == ST_REQ);
        insv_d = (state_d == ST_SERVICE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            pend_q     <= '0;
            mask_q     <= '0;
            cause_v_q  <= 1'b0;
            cause_id_q <= 4'd0;
            state_q    <= ST_IDLE;
            int_q      <= 1'b0;
            insv_q     <= 1'b0;
        end else begin
            s1_q       <= irq;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            cause_v_q  <= cause_v_d;
            cause_id_q <= cause_id_d;
            state_q    <= state_d;
            int_q      <= int_d;
            insv_q     <= insv_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (addr)
                2'd0:    rdata = 32'(pend_q);
                2'd1:    rdata = 32'(mask_q);
                2'd2:    rdata = {cause_v_q, 27'd0, cause_id_q};
                default: rdata = 32'd0;
            endcase
        end
    end

    assign INT        = int_q;
    assign in_service = insv_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl against a rule-level reference model
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  irq = 8'h00;
    logic        trap_taken = 1'b0;
    logic        mret = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        INT;
    logic        in_service;

    int n_checks = 0;
    int n_fail = 0;

    localparam int M_IDLE = 0;
    localparam int M_REQ = 1;
    localparam int M_SERVICE = 2;

    // Reference model state
    logic [7:0] m_h0, m_h1, m_h2;   // irq sampled at the last three edges
    logic [7:0] m_pend, m_mask;
    logic       m_cv;
    int         m_cid;
    int         m_mode;

    int_ctrl #(.NUM_IRQ(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .trap_taken (trap_taken),
        .mret       (mret),
        .sel        (sel),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .INT        (INT),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_h0 = 0; m_h1 = 0; m_h2 = 0;
        m_pend = 0; m_mask = 0; m_cv = 0; m_cid = 0; m_mode = M_IDLE;
    endtask

    function automatic logic [31:0] exp_reg(input logic [1:0] a);
        case (a)
            2'd0:    return {24'd0, m_pend};
            2'd1:    return {24'd0, m_mask};
            2'd2:    return {m_cv, 27'd0, 4'(m_cid)};
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock: predict the model from current inputs, clock, then
    // drop the one-shot inputs 1ns after the edge.
    task automatic step();
        logic [7:0] rising, act, n_pend, n_mask;
        int win, n_mode, n_cid;
        logic n_cv;
        rising = m_h1 & ~m_h2;
        act = m_pend & m_mask;
        win = -1;
        for (int i = 7; i >= 0; i--) if (act[i]) win = i;
        n_pend = m_pend;
        if (sel && we && addr == 2'd0) n_pend = n_pend & ~wdata[7:0];
        n_mask = (sel && we && addr == 2'd1) ? wdata[7:0] : m_mask;
        n_mode = m_mode; n_cv = m_cv; n_cid = m_cid;
        if (m_mode == M_IDLE) begin
            if (act != 0) n_mode = M_REQ;
        end else if (m_mode == M_REQ) begin
            if (trap_taken && win >= 0) begin
                n_mode = M_SERVICE; n_pend[win] = 1'b0; n_cv = 1'b1; n_cid = win;
            end else if (act == 0) begin
                n_mode = M_IDLE;
            end
        end else begin
            if (mret) begin n_mode = M_IDLE; n_cv = 1'b0; end
        end
        n_pend = n_pend | rising;
        @(posedge clk);
        if (rst) begin
            m_h2 = m_h1; m_h1 = m_h0; m_h0 = irq;
            m_pend = n_pend; m_mask = n_mask; m_mode = n_mode; m_cv = n_cv; m_cid = n_cid;
        end else begin
            model_reset();
        end
        #1;
        trap_taken = 0; mret = 0; sel = 0; we = 0;
    endtask

    task automatic rd(input logic [1:0] a);
        sel = 1; we = 0; addr = a; #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1; we = 1; addr = a; wdata = d;
    endtask

    task automatic test_reset();
        rst = 0; irq = 8'hFF; model_reset();
        repeat (2) @(posedge clk);
        #2;
        n_checks++; if (INT !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b want 0", INT); end
        n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL reset_insv: got %b want 0", in_service); end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            n_checks++;
            if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h want 0", a, rdata); end
        end
        sel = 0;
        rst = 1;
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++; if (INT !== 1'b0) begin n_fail++; $display("FAIL reset_masked_int c%0d: got %b want 0", c, INT); end
        end
        rd(2'd0);
        n_checks++; if (rdata !== 32'hFF) begin n_fail++; $display("FAIL reset_pend_after: got %h want 000000ff", rdata); end
        irq = 8'h00;
        wr(2'd0, 32'hFF); step();
        repeat (3) step();
    endtask

    task automatic test_latency();
        wr(2'd1, 32'h01); step();
        irq[0] = 1'b1;
        step(); step();
        rd(2'd0);
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL lat_pend_e1: got %h want 0", rdata); end
        step();
        rd(2'd0);
        n_checks++; if (rdata !== 32'h01) begin n_fail++; $display("FAIL lat_pend_e2: got %h want 1", rdata); end
        n_checks++; if (INT !== 1'b0) begin n_fail++; $display("FAIL lat_int_e2: got %b want 0", INT); end
        step();
        n_checks++; if (INT !== 1'b1) begin n_fail++; $display("FAIL lat_int_e3: got %b want 1", INT); end
        trap_taken = 1; step();
        n_checks++; if (INT !== 1'b0 || in_service !== 1'b1) begin n_fail++; $display("FAIL lat_trap: INT=%b insv=%b want 0/1", INT, in_service); end
        rd(2'd2);
        n_checks++; if (rdata !== 32'h8000_0000) begin n_fail++; $display("FAIL lat_cause: got %h want 80000000", rdata); end
        rd(2'd0);
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL lat_pend_clr: got %h want 0", rdata); end
        mret = 1; step();
        n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL lat_mret: insv=%b want 0", in_service); end
        irq = 0; repeat (3) step();
    endtask

    task automatic test_priority();
        wr(2'd1, 32'hFF); step();
        irq = 8'h24;
        repeat (4) step();
        n_checks++; if (INT !== 1'b1) begin n_fail++; $display("FAIL prio_int: got %b want 1", INT); end
        trap_taken = 1; step();
        rd(2'd2);
        n_checks++; if (rdata !== 32'h8000_0002) begin n_fail++; $display("FAIL prio_cause1: got %h want 80000002", rdata); end
        mret = 1; step();
        n_checks++; if (INT !== 1'b0) begin n_fail++; $display("FAIL prio_idle: got %b want 0", INT); end
        rd(2'd2);
        n_checks++; if (rdata !== 32'h0000_0002) begin n_fail++; $display("FAIL prio_cause_keep: got %h want 00000002", rdata); end
        step();
        n_checks++; if (INT !== 1'b1) begin n_fail++; $display("FAIL prio_rereq: got %b want 1", INT); end
        trap_taken = 1; step();
        rd(2'd2);
        n_checks++; if (rdata !== 32'h8000_0005) begin n_fail++; $display("FAIL prio_cause2: got %h want 80000005", rdata); end
        mret = 1; step();
        irq = 0; repeat (3) step();
    endtask

    task automatic test_withdraw();
        irq[7] = 1'b1;
        repeat (4) step();
        n_checks++; if (INT !== 1'b1) begin n_fail++; $display("FAIL wd_int: got %b want 1", INT); end
        wr(2'd1, 32'h0); step();
        step();
        n_checks++; if (INT !== 1'b0) begin n_fail++; $display("FAIL wd_drop: got %b want 0", INT); end
        rd(2'd0);
        n_checks++; if (rdata !== 32'h80) begin n_fail++; $display("FAIL wd_pend: got %h want 00000080", rdata); end
        wr(2'd1, 32'hFF); step();
        step();
        n_checks++; if (INT !== 1'b1) begin n_fail++; $display("FAIL wd_reassert: got %b want 1", INT); end
        trap_taken = 1; step();
        mret = 1; step();
        irq = 0; repeat (3) step();
    endtask

    task automatic test_w1c_race();
        irq[3] = 1'b1;
        step(); step();
        wr(2'd0, 32'h08); step();
        rd(2'd0);
        n_checks++; if (rdata !== 32'h08) begin n_fail++; $display("FAIL race_pend: got %h want 00000008", rdata); end
        step();
        trap_taken = 1; step();
        rd(2'd2);
        n_checks++; if (rdata !== 32'h8000_0003) begin n_fail++; $display("FAIL race_cause: got %h want 80000003", rdata); end
    endtask

    task automatic test_no_nesting();
        irq[1] = 1'b1;
        repeat (4) step();
        rd(2'd0);
        n_checks++; if (rdata !== 32'h02) begin n_fail++; $display("FAIL nest_pend: got %h want 00000002", rdata); end
        n_checks++; if (INT !== 1'b0 || in_service !== 1'b1) begin n_fail++; $display("FAIL nest_hold: INT=%b insv=%b want 0/1", INT, in_service); end
        trap_taken = 1; step();
        n_checks++; if (INT !== 1'b0 || in_service !== 1'b1) begin n_fail++; $display("FAIL nest_trap_ign: INT=%b insv=%b want 0/1", INT, in_service); end
        #2 rst = 0; model_reset();
        rd(2'd2);
        n_checks++; if (in_service !== 1'b0 || INT !== 1'b0) begin n_fail++; $display("FAIL midrst_out: INT=%b insv=%b want 0/0", INT, in_service); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_cause: got %h want 0", rdata); end
        sel = 0; irq = 0;
        @(negedge clk); rst = 1;
        repeat (3) step();
    endtask

    task automatic test_random();
        logic [1:0] a;
        int op;
        for (int c = 0; c < 400; c++) begin
            n_checks++;
            if (INT !== (m_mode == M_REQ) || in_service !== (m_mode == M_SERVICE)) begin
                n_fail++;
                $display("FAIL rand_out c%0d: INT=%b insv=%b want %b/%b", c, INT, in_service, m_mode == M_REQ, m_mode == M_SERVICE);
            end
            a = 2'($urandom_range(0, 3));
            sel = ($urandom_range(0, 7) != 0); we = 0; addr = a; #1;
            n_checks++;
            if (rdata !== (sel ? exp_reg(a) : 32'd0)) begin
                n_fail++;
                $display("FAIL rand_rdata c%0d a%0d sel%b: got %h want %h", c, a, sel, rdata, sel ? exp_reg(a) : 32'd0);
            end
            if ($urandom_range(0, 3) == 0) irq[$urandom_range(0, 7)] ^= 1'b1;
            op = $urandom_range(0, 11);
            case (op)
                0: wr(2'd0, $urandom);
                1: wr(2'd1, $urandom);
                2: wr(2'($urandom_range(2, 3)), $urandom);
                3, 4, 5: trap_taken = 1;
                6, 7: mret = 1;
                default: ;
            endcase
            step();
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_priority();
        test_withdraw();
        test_w1c_race();
        test_no_nesting();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
